// File: rtl/kmeans_centroid_update.sv
// kmeans_centroid_update: reader side of the k=2, n=2 k-means accumulator.
// Reads the per-centroid coordinate sums and point counts, divides them with
// two sequential restoring dividers (one per dimension) and presents the new
// centroids with a one-cycle up_centroids strobe and a convergence flag.

// One restoring-divider lane: loads a dividend, then performs one MSB-first
// restoring step per enabled cycle. The dividend register doubles as the
// quotient register: each step shifts a dividend bit out and a quotient bit in.
module kmeans_div_lane #(
  parameter int acc_sum_width = 24,
  parameter int cnt_width     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic [acc_sum_width-1:0] dividend,
  input  logic [cnt_width-1:0]     divisor,
  output logic [acc_sum_width-1:0] quotient
);

  logic [cnt_width:0]   rem;
  logic [cnt_width+1:0] rem_wide;
  logic [cnt_width+1:0] divisor_wide;
  logic [cnt_width:0]   rem_next;
  logic                 fits;

  // Trial subtraction of one restoring step. The remainder is always below the
  // divisor, so the shifted value minus the divisor fits back into rem.
  always_comb begin
    rem_wide     = {rem, quotient[acc_sum_width-1]};
    divisor_wide = (cnt_width+2)'(divisor);
    fits         = (rem_wide >= divisor_wide);
    rem_next     = fits ? (cnt_width+1)'(rem_wide - divisor_wide)
                        : (cnt_width+1)'(rem_wide);
  end

  // Remainder / dividend-quotient shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem      <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= '0;
      quotient <= dividend;
    end else if (step) begin
      rem      <= rem_next;
      quotient <= {quotient[acc_sum_width-2:0], fits};
    end
  end

endmodule

// Sequencer for the two centroids.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | waiting for start; done/converged hold the last result
//   LOAD   | sum memories addressed by idx; dividends and count latched
//   DIV    | acc_sum_width restoring steps, both dimensions in parallel
//   STORE  | quotient (or kept centroid for an empty cluster) written to _n
//   UPDATE | up_centroids strobe, done set, back to IDLE
module kmeans_centroid_update #(
  parameter int data_width    = 16,
  parameter int acc_sum_width = 24,
  parameter int cnt_width     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     sum_rd_addr,
  input  logic [acc_sum_width-1:0] sum_d0_in,
  input  logic [acc_sum_width-1:0] sum_d1_in,
  input  logic [cnt_width-1:0]     k0_count,
  input  logic [cnt_width-1:0]     k1_count,
  input  logic [data_width-1:0]    k0_0,
  input  logic [data_width-1:0]    k0_1,
  input  logic [data_width-1:0]    k1_0,
  input  logic [data_width-1:0]    k1_1,
  output logic [data_width-1:0]    k0_0_n,
  output logic [data_width-1:0]    k0_1_n,
  output logic [data_width-1:0]    k1_0_n,
  output logic [data_width-1:0]    k1_1_n,
  output logic                     up_centroids,
  output logic                     busy,
  output logic                     done,
  output logic                     converged
);

  localparam int iter_width = $clog2(acc_sum_width);
  localparam logic [iter_width-1:0] iter_last = iter_width'(acc_sum_width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIV    = 3'd2,
    STORE  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  state_t                  state;
  logic                    idx;
  logic [iter_width-1:0]   iter;
  logic [cnt_width-1:0]    divisor;
  logic                    lane_load;
  logic                    lane_step;
  logic [acc_sum_width-1:0] quot_d0;
  logic [acc_sum_width-1:0] quot_d1;
  logic [data_width-1:0]   keep_d0;
  logic [data_width-1:0]   keep_d1;
  logic [data_width-1:0]   new_d0;
  logic [data_width-1:0]   new_d1;
  logic                    quot_unused;

  // Both memories are asynchronous-read and share the centroid index.
  assign sum_rd_addr = idx;

  assign lane_load = (state == LOAD);
  assign lane_step = (state == DIV);

  kmeans_div_lane #(
    .acc_sum_width (acc_sum_width),
    .cnt_width     (cnt_width)
  ) u_div_d0 (
    .clk      (clk),
    .rst      (rst),
    .load     (lane_load),
    .step     (lane_step),
    .dividend (sum_d0_in),
    .divisor  (divisor),
    .quotient (quot_d0)
  );

  kmeans_div_lane #(
    .acc_sum_width (acc_sum_width),
    .cnt_width     (cnt_width)
  ) u_div_d1 (
    .clk      (clk),
    .rst      (rst),
    .load     (lane_load),
    .step     (lane_step),
    .dividend (sum_d1_in),
    .divisor  (divisor),
    .quotient (quot_d1)
  );

  // The mean never exceeds the coordinate range, so the quotient MSBs are
  // always zero and are dropped.
  assign quot_unused = ^{quot_d0[acc_sum_width-1:data_width],
                         quot_d1[acc_sum_width-1:data_width]};

  // New centroid for the current idx; an empty cluster keeps its old position.
  always_comb begin
    keep_d0 = idx ? k1_0 : k0_0;
    keep_d1 = idx ? k1_1 : k0_1;
    if (divisor == '0) begin
      new_d0 = keep_d0;
      new_d1 = keep_d1;
    end else begin
      new_d0 = quot_d0[data_width-1:0];
      new_d1 = quot_d1[data_width-1:0];
    end
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      idx          <= 1'b0;
      iter         <= '0;
      divisor      <= '0;
      k0_0_n       <= '0;
      k0_1_n       <= '0;
      k1_0_n       <= '0;
      k1_1_n       <= '0;
      up_centroids <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
    end else begin
      up_centroids <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          divisor <= idx ? k1_count : k0_count;
          iter    <= '0;
          state   <= DIV;
        end
        DIV: begin
          if (iter == iter_last) begin
            state <= STORE;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        STORE: begin
          if (!idx) begin
            k0_0_n <= new_d0;
            k0_1_n <= new_d1;
            idx    <= 1'b1;
            state  <= LOAD;
          end else begin
            k1_0_n       <= new_d0;
            k1_1_n       <= new_d1;
            // Compared against the values being written so the flag is
            // ready in the same cycle as the strobe.
            converged    <= (k0_0_n == k0_0) && (k0_1_n == k0_1) &&
                            (new_d0 == k1_0) && (new_d1 == k1_1);
            up_centroids <= 1'b1;
            done         <= 1'b1;
            state        <= UPDATE;
          end
        end
        UPDATE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_centroid_update.sv
// Directed bench for kmeans_centroid_update: a behavioural timing/result model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_kmeans_centroid_update;

  localparam int DW = 16;
  localparam int SW = 24;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sum_rd_addr;
  logic [SW-1:0] sum_d0_in, sum_d1_in;
  logic [CW-1:0] k0_count, k1_count;
  logic [DW-1:0] k0_0, k0_1, k1_0, k1_1;
  logic [DW-1:0] k0_0_n, k0_1_n, k1_0_n, k1_1_n;
  logic up_centroids, busy, done, converged;

  logic [SW-1:0] mem_d0 [2];
  logic [SW-1:0] mem_d1 [2];
  logic [CW-1:0] cnt [2];
  logic [DW-1:0] cur [4];

  always #5 clk = ~clk;

  // Asynchronous-read sum memories.
  assign sum_d0_in = mem_d0[sum_rd_addr];
  assign sum_d1_in = mem_d1[sum_rd_addr];
  assign k0_count  = cnt[0];
  assign k1_count  = cnt[1];
  assign k0_0 = cur[0];
  assign k0_1 = cur[1];
  assign k1_0 = cur[2];
  assign k1_1 = cur[3];

  kmeans_centroid_update #(
    .data_width    (DW),
    .acc_sum_width (SW),
    .cnt_width     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sum_rd_addr  (sum_rd_addr),
    .sum_d0_in    (sum_d0_in),
    .sum_d1_in    (sum_d1_in),
    .k0_count     (k0_count),
    .k1_count     (k1_count),
    .k0_0         (k0_0),
    .k0_1         (k0_1),
    .k1_0         (k1_0),
    .k1_1         (k1_1),
    .k0_0_n       (k0_0_n),
    .k0_1_n       (k0_1_n),
    .k1_0_n       (k1_0_n),
    .k1_1_n       (k1_1_n),
    .up_centroids (up_centroids),
    .busy         (busy),
    .done         (done),
    .converged    (converged)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mean(input logic [SW-1:0] s,
                                         input logic [CW-1:0] c,
                                         input logic [DW-1:0] keep);
    if (c == 0) return keep;
    return DW'(int'(s) / int'(c));
  endfunction

  // Model: an accepted start is followed 52 edges later by the strobe;
  // busy covers 53 cycles; results are floor(sum/count) or the kept centroid.
  int            ph = -1;
  logic          e_busy = 1'b0, e_up = 1'b0, e_done = 1'b0, e_conv = 1'b0;
  logic [DW-1:0] e_n [4] = '{default: '0};
  logic [DW-1:0] pend [4] = '{default: '0};

  always @(posedge clk) begin
    if (!rst) begin
      ph     <= -1;
      e_busy <= 1'b0;
      e_up   <= 1'b0;
      e_done <= 1'b0;
      e_conv <= 1'b0;
      for (int i = 0; i < 4; i++) e_n[i] <= '0;
    end else if (ph < 0) begin
      if (start) begin
        ph      <= 0;
        e_busy  <= 1'b1;
        e_done  <= 1'b0;
        e_conv  <= 1'b0;
        pend[0] <= mean(mem_d0[0], cnt[0], cur[0]);
        pend[1] <= mean(mem_d1[0], cnt[0], cur[1]);
        pend[2] <= mean(mem_d0[1], cnt[1], cur[2]);
        pend[3] <= mean(mem_d1[1], cnt[1], cur[3]);
      end
    end else begin
      if (ph == 51) begin
        e_up   <= 1'b1;
        e_done <= 1'b1;
        e_conv <= (pend[0] == cur[0]) && (pend[1] == cur[1]) &&
                  (pend[2] == cur[2]) && (pend[3] == cur[3]);
        for (int i = 0; i < 4; i++) e_n[i] <= pend[i];
      end
      if (ph == 52) begin
        e_up   <= 1'b0;
        e_busy <= 1'b0;
        ph     <= -1;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("up_centroids", up_centroids, e_up);
      chk("done", done, e_done);
      if (e_done) chk("converged", converged, e_conv);
      if (ph < 0 || e_up) begin
        chk("k0_0_n", k0_0_n, e_n[0]);
        chk("k0_1_n", k0_1_n, e_n[1]);
        chk("k1_0_n", k1_0_n, e_n[2]);
        chk("k1_1_n", k1_1_n, e_n[3]);
      end
    end
  end

  task automatic wait_up(input string name);
    int n = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      if (up_centroids) seen = 1'b1;
    end
    chk(name, seen ? n : 999, 52);
  endtask

  task automatic do_op(input string name, input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    wait_up(name);
  endtask

  task automatic set_data(input int s00, input int s10, input int s01, input int s11,
                          input int c0, input int c1,
                          input int a, input int b, input int c, input int d);
    mem_d0[0] = SW'(s00); mem_d0[1] = SW'(s01);
    mem_d1[0] = SW'(s10); mem_d1[1] = SW'(s11);
    cnt[0] = CW'(c0); cnt[1] = CW'(c1);
    cur[0] = DW'(a); cur[1] = DW'(b); cur[2] = DW'(c); cur[3] = DW'(d);
  endtask

  initial begin
    set_data(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_addr", sum_rd_addr, 0);
    chk("reset_k0_0_n", k0_0_n, 0);
    chk("reset_up", up_centroids, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic divide
    set_data(100, 40, 600, 900, 10, 30, 0, 0, 1, 1);
    do_op("latency_basic", 1'b0);
    chk("basic_k0_0", k0_0_n, 10);
    chk("basic_k0_1", k0_1_n, 4);
    chk("basic_k1_0", k1_0_n, 20);
    chk("basic_k1_1", k1_1_n, 30);
    chk("basic_conv", converged, 0);
    repeat (3) @(posedge clk);
    #1;

    // Floor truncation, maximum dividend
    set_data(7, 9, 24'hFFFFFF, 256000, 2, 256, 0, 0, 0, 0);
    do_op("latency_floor", 1'b0);
    chk("floor_k0_0", k0_0_n, 3);
    chk("floor_k0_1", k0_1_n, 4);
    chk("floor_k1_0", k1_0_n, 65535);
    chk("floor_k1_1", k1_1_n, 1000);
    repeat (3) @(posedge clk);
    #1;

    // Empty cluster keeps its centroid
    set_data(44, 8, 123, 77, 4, 0, 0, 0, 5, 9);
    do_op("latency_empty", 1'b0);
    chk("empty_k0_0", k0_0_n, 11);
    chk("empty_k0_1", k0_1_n, 2);
    chk("empty_k1_0", k1_0_n, 5);
    chk("empty_k1_1", k1_1_n, 9);
    repeat (3) @(posedge clk);
    #1;

    // Convergence, then one value changed
    set_data(50, 100, 300, 60, 5, 6, 10, 20, 50, 10);
    do_op("latency_conv", 1'b0);
    chk("conv_flag", converged, 1);
    repeat (3) @(posedge clk);
    #1;
    cur[3] = 16'd11;
    do_op("latency_noconv", 1'b0);
    chk("noconv_flag", converged, 0);
    chk("noconv_k1_1", k1_1_n, 10);
    repeat (3) @(posedge clk);
    #1;

    // start held high: one update, then a fresh one from IDLE
    set_data(100, 40, 600, 900, 10, 30, 0, 0, 1, 1);
    do_op("latency_hold", 1'b1);
    @(posedge clk); #1;
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_done", done, 1);
    chk("hold_idle_up", up_centroids, 0);
    @(posedge clk); #1;
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_done", done, 0);
    start = 1'b0;
    wait_up("latency_second");
    chk("second_k1_0", k1_0_n, 20);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the divide of centroid 1
    set_data(70, 21, 99, 33, 7, 3, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_k0_0", k0_0_n, 0);
    chk("abort_addr", sum_rd_addr, 0);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    do_op("latency_after_reset", 1'b0);
    chk("after_k0_0", k0_0_n, 10);
    chk("after_k0_1", k0_1_n, 3);
    chk("after_k1_0", k1_0_n, 33);
    chk("after_k1_1", k1_1_n, 11);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kmeans_centroid_update.md
Name: kmeans_centroid_update

Overview:
- Reader side of the k=2, n=2 k-means accumulator path.
- After a classification pass, it reads per-centroid coordinate sums from the sum memories and the per-centroid point counts.
- It computes the new centroids as floor(sum/count) with two sequential restoring dividers, one per dimension.
- It then presents k0_0_n..k1_1_n to the kmeans top with a one-cycle up_centroids strobe and a convergence flag.

Parameters:
- data_width, 16, centroid/coordinate width.
- acc_sum_width, 24, width of accumulated sums (W); also the divider iteration count.
- cnt_width, 9, width of point counters (n_input_data_b_depth+1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low (rst==0 resets).
- start  input  1  begin update; sampled only in IDLE.
- sum_rd_addr  output  1  centroid index driven to both sum memories (asynchronous read).
- sum_d0_in  input  acc_sum_width  sum memory d0 read data.
- sum_d1_in  input  acc_sum_width  sum memory d1 read data.
- k0_count  input  cnt_width  points assigned to centroid 0.
- k1_count  input  cnt_width  points assigned to centroid 1.
- k0_0, k0_1, k1_0, k1_1  input  data_width each  current centroids.
- k0_0_n, k0_1_n, k1_0_n, k1_1_n  output  data_width each  new centroids (registered).
- up_centroids  output  1  one-cycle strobe: the _n outputs are valid and final.
- busy  output  1  high from LOAD through UPDATE.
- done  output  1  level; high from UPDATE until the next accepted start or reset.
- converged  output  1  valid while done; 1 iff all four new values equal the current values.

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; all outputs 0, including the _n registers, sum_rd_addr, busy, done, converged and up_centroids. Reset mid-operation aborts the update with no up_centroids pulse.
- FSM: IDLE -> LOAD -> DIV -> STORE -> (LOAD for centroid 1 | UPDATE) -> IDLE.
- IDLE: start==1 captures idx=0, clears done, and goes to LOAD.
- LOAD (1 cycle):
  - sum_rd_addr=idx.
  - Latch sum_d0_in and sum_d1_in as dividends.
  - Latch k{idx}_count as divisor.
  - Clear the partial remainder and the iteration counter.
- DIV (exactly W cycles): one restoring step per cycle per dimension, MSB first.
  - rem = {rem, dividend bit}.
  - If rem >= divisor: rem -= divisor and quotient bit = 1; else quotient bit = 0.
  - Remainder width is cnt_width+1 bits; quotient is W bits.
- STORE (1 cycle):
  - k{idx}_x_n <= quotient[data_width-1:0]. Truncation is exact because the mean never exceeds the data range.
  - If the divisor is 0, k{idx}_x_n <= current k{idx}_x (centroid kept). The divider still runs its W cycles, so latency is fixed.
  - Then idx=0 -> idx=1, go to LOAD; idx=1 -> UPDATE.
- UPDATE (1 cycle): up_centroids=1, done=1, converged computed from the registered _n values vs current inputs. Next state IDLE.
- Latency: up_centroids is high in the cycle following the 2W+4-th edge after the start-sampling edge, i.e. 52 edges for W=24. busy is high for 2W+5 cycles.
- start while busy: ignored. start on the UPDATE cycle: ignored. start in IDLE with done=1: accepted.
- The current-centroid inputs must stay stable from start to UPDATE; the kmeans top guarantees this because it only loads centroids on up_centroids.
- Sum/count inputs are sampled only in LOAD; later changes have no effect.

Test Plan:
- Basic divide: sums d0 {0:100, 1:600}, d1 {0:40, 1:900}, counts 10/30 -> k0_n=(10,4), k1_n=(20,30). up_centroids single pulse 52 edges after start; converged=0 with current (0,0),(1,1).
- Floor truncation: sum 7, count 2 -> 3; sum 2^24-1, count 256 -> 65535. Check the maximum-width dividend.
- Empty cluster: k1_count=0, current k1=(5,9) -> k1_n=(5,9); k0 divides normally; latency unchanged.
- Convergence: current centroids equal computed means (e.g. sum 50, count 5, current 10) for all four -> converged=1 with up_centroids. Changing one value -> converged=0.
- start held high through the whole operation -> exactly one update. A second update begins only after return to IDLE; done stays high between them.
- rst=0 asserted during the DIV of centroid 1 -> no up_centroids; all outputs 0 next cycle. A fresh start then yields correct results.
